// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter4
// Description : Round-robin arbiter sharing one resource among 4 requesters.
//               Grant is a registered one-hot vector plus its 2-bit encoded
//               index. An owner keeps the grant until it asserts done_i or
//               drops its request. Every release is followed by one GAP
//               cycle and one IDLE arbitration cycle.
//
// Ports       : clk            in   1  rising-edge clock
//               rst            in   1  asynchronous reset, active-high
//               req_i          in   4  request per requester (bit i = req i)
//               done_i         in   1  owner releases; ignored unless granted
//               grant_o        out  4  one-hot grant, registered
//               grant_idx_o    out  2  encoded grant index, registered
//               grant_valid_o  out  1  grant is active
//               timeout_o      out  1  1-cycle pulse, grant revoked by limit
//
// Parameters  : MAX_HOLD  maximum grant length in cycles (timeout build only)
//               CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
//
// Config macro: ARB_TIMEOUT_EN - when defined, a grant that is not released
//               is revoked after MAX_HOLD cycles and timeout_o pulses. When
//               undefined, grants are unbounded and timeout_o stays 0.
//
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter4 #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_i,
  input  logic       done_i,
  output logic [3:0] grant_o,
  output logic [1:0] grant_idx_o,
  output logic       grant_valid_o,
  output logic       timeout_o
);

  // Elaboration-time guard: the hold counter must be able to reach MAX_HOLD-1.
  if (2**CNT_W <= MAX_HOLD) begin : g_cnt_w_check
    $error("rr_arbiter4: CNT_W is too narrow for MAX_HOLD");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] grant_idx_q, grant_idx_d;
  logic       grant_valid_q, grant_valid_d;
  logic       timeout_q, timeout_d;
  logic [1:0] last_idx_q, last_idx_d;

  logic [1:0] w_winner_idx;
  logic       w_winner_found;
  logic       w_release;
  logic       w_hold_expired;

  // --------------------------------------------------------------------------
  // Hold limit
  // --------------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  // Counter sits at 0 outside BUSY, so it is already clear on BUSY entry.
  // Its value equals the number of completed BUSY cycles before this one.
  always_comb begin
    hold_cnt_d = '0;
    if (state_q == ST_BUSY) begin
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // True in the last permitted BUSY cycle (the MAX_HOLD-th one).
  assign w_hold_expired = (state_q == ST_BUSY) && (hold_cnt_q == c_HOLD_LAST);
`else
  assign w_hold_expired = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Round-robin winner: first set request scanning last_idx+1 .. last_idx+4.
  // The 2-bit addition wraps, which gives the modulo-4 rotation for free.
  // --------------------------------------------------------------------------
  always_comb begin
    w_winner_idx   = 2'd0;
    w_winner_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!w_winner_found && req_i[2'(last_idx_q + 2'(k))]) begin
        w_winner_found = 1'b1;
        w_winner_idx   = 2'(last_idx_q + 2'(k));
      end
    end
  end

  // done together with a request drop is still a single release event.
  assign w_release = done_i || !req_i[grant_idx_q];

  // --------------------------------------------------------------------------
  // Next-state and registered-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    last_idx_d    = last_idx_q;
    timeout_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (w_winner_found) begin
          state_d       = ST_BUSY;
          grant_d       = 4'b0001 << w_winner_idx;
          grant_idx_d   = w_winner_idx;
          grant_valid_d = 1'b1;
        end
      end

      ST_BUSY: begin
        if (w_release || w_hold_expired) begin
          state_d       = ST_GAP;
          grant_d       = 4'b0000;
          grant_idx_d   = 2'd0;
          grant_valid_d = 1'b0;
          last_idx_d    = grant_idx_q;
          // A genuine release in the final hold cycle wins over the timeout.
          timeout_d     = !w_release;
        end
      end

      ST_GAP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d       = ST_IDLE;
        grant_d       = 4'b0000;
        grant_idx_d   = 2'd0;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= 4'b0000;
      grant_idx_q   <= 2'd0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      // Priority after reset starts at requester 0.
      last_idx_q    <= 2'd3;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
      last_idx_q    <= last_idx_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_idx_o   = grant_idx_q;
  assign grant_valid_o = grant_valid_q;
  assign timeout_o     = timeout_q;

endmodule
`default_nettype wire
